// File: rtl/conv_acc_pkg.sv
// Shared constants and helpers for the conv accelerator datapath: feature-map geometry,
// 3x3 tap ordering (common with the window-enable counter stage) and saturating add.
package conv_acc_pkg;

    localparam int FMAP_W   = 112;
    localparam int PIX_NUM  = FMAP_W * FMAP_W;
    localparam int TAP_NUM  = 9;
    localparam int TAP_ROWS = 3;
    localparam int TAP_COLS = 3;

    // Taps are numbered row-major across the window; tap k pairs with enable(k+1).
    function automatic int tap_idx(input int row, input int col);
        return row * TAP_COLS + col;
    endfunction

    // Signed add of two sign-extended operands, clamped to a w-bit signed range (w <= 63).
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [64:0] sum;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        sum = {a[63], a} + {b[63], b};
        hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo  = -(65'sd1 <<< (w - 1));
        if (sum > hi) return hi[63:0];
        if (sum < lo) return lo[63:0];
        return sum[63:0];
    endfunction

endpackage

// File: rtl/conv_psum_accum_psum_ram.sv
// Partial-sum storage: simple dual-port RAM, one write and one registered read per cycle.
module psum_ram #(
    parameter int DEPTH  = 12544,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage carries no reset so it maps onto block RAM; every address is
    // overwritten by the first channel before it is ever read back.
    always_ff @(posedge clk) begin
        if (we)    mem[wr_addr] <= wr_data;
        if (rd_en) rd_data      <= mem[rd_addr];
    end

endmodule

// File: rtl/conv_psum_accum.sv
// Masks 3x3 tap products, reduces them in a 3-stage pipeline and accumulates per-pixel
// partial sums across input channels. Define CONV_PSUM_RELU_EN to clip final outputs at 0.
module conv_psum_accum #(
    parameter int PROD_W   = 16,
    parameter int ACC_W    = 32,
    parameter int PIX_NUM  = conv_acc_pkg::PIX_NUM,
    parameter int NUM_CHNL = 64,
    parameter int ADDR_W   = 14,
    parameter int CH_W     = 7
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   valid_i,
    input  logic [conv_acc_pkg::TAP_NUM*PROD_W-1:0] prod_i,
    input  logic [conv_acc_pkg::TAP_NUM-1:0]        en_i,
    input  logic                                   chnl_done_i,
    output logic                                   out_valid_o,
    output logic [ACC_W-1:0]                       out_data_o,
    output logic                                   out_last_o,
    output logic                                   layer_done_o,
    output logic                                   err_o
);
    import conv_acc_pkg::*;

    localparam int                ROW_W    = PROD_W + 2;
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIX_NUM - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CHNL - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              first;
        logic              last;
        logic              layer;
    } tag_t;

    logic [ADDR_W-1:0]        pix_addr;
    logic [CH_W-1:0]          chnl_idx;
    logic                     pix_wrap;
    logic                     chnl_wrap;
    logic signed [PROD_W-1:0] tap     [TAP_NUM];
    logic signed [ROW_W-1:0]  row_sum [TAP_ROWS];
    logic signed [ROW_W-1:0]  s1_row  [TAP_ROWS];
    logic                     s1_valid;
    logic                     s2_valid;
    tag_t                     s1_tag;
    tag_t                     s2_tag;
    logic signed [ACC_W-1:0]  s2_win;
    logic signed [ACC_W-1:0]  ram_rd;
    logic signed [ACC_W-1:0]  new_sum;
    logic signed [ACC_W-1:0]  out_val;

    assign pix_wrap  = (pix_addr == PIX_LAST);
    assign chnl_wrap = (chnl_idx == CH_LAST);

    // NOTE: every tap and row entry is assigned on every pass, so no latch can form.
    always_comb begin
        for (int k = 0; k < TAP_NUM; k++)
            tap[k] = en_i[k] ? $signed(prod_i[k*PROD_W +: PROD_W]) : '0;
        for (int r = 0; r < TAP_ROWS; r++)
            row_sum[r] = ROW_W'(tap[tap_idx(r, 0)]) + ROW_W'(tap[tap_idx(r, 1)])
                       + ROW_W'(tap[tap_idx(r, 2)]);
    end

    // A chnl_done on any pixel other than the last flags an error and resyncs to pixel 0.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_addr <= '0;
            chnl_idx <= '0;
            err_o    <= 1'b0;
        end else if (valid_i) begin
            if (chnl_done_i) begin
                pix_addr <= '0;
                chnl_idx <= chnl_wrap ? '0 : chnl_idx + 1'b1;
                if (!pix_wrap) err_o <= 1'b1;
            end else begin
                pix_addr <= pix_wrap ? '0 : pix_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_tag   <= '0;
            s2_tag   <= '0;
            s1_row   <= '{default: '0};
            s2_win   <= '0;
        end else begin
            s1_valid <= valid_i;
            s2_valid <= s1_valid;
            if (valid_i) begin
                s1_row <= row_sum;
                s1_tag <= '{addr:  pix_addr,
                            first: (chnl_idx == '0),
                            last:  chnl_wrap,
                            layer: chnl_done_i & pix_wrap & chnl_wrap};
            end
            if (s1_valid) begin
                s2_tag <= s1_tag;
                s2_win <= ACC_W'(s1_row[0]) + ACC_W'(s1_row[1]) + ACC_W'(s1_row[2]);
            end
        end
    end

    // The read is issued from the S1 tag so its data lands alongside the S2 window sum.
    psum_ram #(
        .DEPTH  (PIX_NUM),
        .DATA_W (ACC_W),
        .ADDR_W (ADDR_W)
    ) u_psum_ram (
        .clk     (clk),
        .we      (s2_valid),
        .wr_addr (s2_tag.addr),
        .wr_data (new_sum),
        .rd_en   (s1_valid),
        .rd_addr (s1_tag.addr),
        .rd_data (ram_rd)
    );

    always_comb begin
        new_sum = s2_tag.first ? s2_win
                               : ACC_W'(sat_add(64'(ram_rd), 64'(s2_win), ACC_W));
`ifdef CONV_PSUM_RELU_EN
        out_val = new_sum[ACC_W-1] ? '0 : new_sum;
`else
        out_val = new_sum;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o  <= 1'b0;
            out_data_o   <= '0;
            out_last_o   <= 1'b0;
            layer_done_o <= 1'b0;
        end else begin
            out_valid_o  <= s2_valid & s2_tag.last;
            out_last_o   <= s2_valid & s2_tag.last & (s2_tag.addr == PIX_LAST);
            layer_done_o <= s2_valid & s2_tag.layer;
            if (s2_valid && s2_tag.last) out_data_o <= out_val;
        end
    end

endmodule

// File: tb/tb_conv_psum_accum.sv
// Directed bench for conv_psum_accum with PIX_NUM=4, NUM_CHNL=2, ACC_W=20.
module tb_conv_psum_accum;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 20;
    localparam logic [8:0] EN_ALL  = 9'h1FF;
    localparam logic [8:0] EN_PAD  = 9'b000_011_011;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 valid_i = 1'b0;
    logic [9*PROD_W-1:0]  prod_i = '0;
    logic [8:0]           en_i = '0;
    logic                 chnl_done_i = 1'b0;
    logic                 out_valid_o;
    logic [ACC_W-1:0]     out_data_o;
    logic                 out_last_o;
    logic                 layer_done_o;
    logic                 err_o;

    int n_assert = 0;
    int n_fail   = 0;

    conv_psum_accum #(
        .PROD_W(PROD_W), .ACC_W(ACC_W), .PIX_NUM(4), .NUM_CHNL(2), .ADDR_W(2), .CH_W(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .prod_i       (prod_i),
        .en_i         (en_i),
        .chnl_done_i  (chnl_done_i),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .layer_done_o (layer_done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9*PROD_W-1:0] uni(input logic signed [PROD_W-1:0] v);
        return {9{v}};
    endfunction

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9*PROD_W-1:0] p, input logic [8:0] en, input logic done);
        valid_i     = 1'b1;
        prod_i      = p;
        en_i        = en;
        chnl_done_i = done;
        cycle();
        valid_i     = 1'b0;
        chnl_done_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, out_valid_o, 0);
        check({tag, "_data"}, $signed(out_data_o), 0);
        check({tag, "_last"}, out_last_o, 0);
        check({tag, "_layer"}, layer_done_o, 0);
    endtask

    // Pads channel 0 pixels 1..3 with zero windows, ending the channel.
    task automatic finish_chnl0();
        push(uni(16'sd0), EN_ALL, 1'b0);
        push(uni(16'sd0), EN_ALL, 1'b0);
        push(uni(16'sd0), EN_ALL, 1'b1);
    endtask

    int a_val [8] = '{1, 2, 3, 4, 10, 20, 30, 40};
    logic [9*PROD_W-1:0] vec;
    logic signed [31:0]  exp_relu;

    initial begin
        // Reset state
        do_reset();
        check_quiet("reset");
        check("reset_err", err_o, 0);
        check("reset_pix", dut.pix_addr, 0);
        check("reset_chnl", dut.chnl_idx, 0);

        // 1. Single window, exact 3-cycle latency
        push(uni(16'sd1), EN_ALL, 1'b0);
        finish_chnl0();
        push(uni(16'sd1), EN_ALL, 1'b0);
        check("t1_lat1", out_valid_o, 0);
        cycle();
        check("t1_lat2", out_valid_o, 0);
        cycle();
        check("t1_valid", out_valid_o, 1);
        check("t1_data", $signed(out_data_o), 18);
        check("t1_last", out_last_o, 0);
        cycle();
        check("t1_pulse", out_valid_o, 0);

        // 2. Padding mask: chnl0 = 63, chnl1 masked = 400
        do_reset();
        push(uni(16'sd7), EN_ALL, 1'b0);
        finish_chnl0();
        push(uni(16'sd100), EN_PAD, 1'b0);
        push(uni(16'sd100), EN_PAD, 1'b0);
        cycle();
        check("t2_valid0", out_valid_o, 1);
        check("t2_sum0", $signed(out_data_o), 463);
        cycle();
        check("t2_valid1", out_valid_o, 1);
        check("t2_sum1", $signed(out_data_o), 400);

        // 3. Full layer: 8 back-to-back windows
        do_reset();
        for (int j = 0; j < 10; j++) begin
            if (j < 8) push(uni(16'(a_val[j])), EN_ALL, (j == 3) || (j == 7));
            else       cycle();
            if (j >= 6) begin
                check($sformatf("t3_valid%0d", j), out_valid_o, 1);
                check($sformatf("t3_data%0d", j), $signed(out_data_o),
                      9 * (a_val[j-2] + a_val[j-6]));
                check($sformatf("t3_last%0d", j), out_last_o, (j == 9) ? 1 : 0);
                check($sformatf("t3_layer%0d", j), layer_done_o, (j == 9) ? 1 : 0);
            end else if (j >= 2) begin
                check($sformatf("t3_idle%0d", j), out_valid_o, 0);
            end
        end
        check("t3_pix", dut.pix_addr, 0);
        check("t3_chnl", dut.chnl_idx, 0);
        check("t3_err", err_o, 0);
        cycle();
        check("t3_layer_off", layer_done_o, 0);

        // 4. Saturation: two window sums of 2^18 exceed the 20-bit range
        do_reset();
        vec = uni(16'sd32767);
        vec[8*PROD_W +: PROD_W] = 16'sd8;
        push(vec, EN_ALL, 1'b0);
        finish_chnl0();
        push(vec, EN_ALL, 1'b0);
        cycle();
        cycle();
        check("t4_valid", out_valid_o, 1);
        check("t4_sat", $signed(out_data_o), 524287);

        // 5. Bubbles, then chnl_done misaligned at pix_addr=2
        do_reset();
        push(uni(16'sd5), EN_ALL, 1'b0);
        cycle();
        cycle();
        push(uni(16'sd6), EN_ALL, 1'b0);
        cycle();
        push(uni(16'sd7), EN_ALL, 1'b0);
        push(uni(16'sd8), EN_ALL, 1'b1);
        cycle();
        push(uni(16'sd1), EN_ALL, 1'b0);
        cycle();
        check("t5_lat", out_valid_o, 0);
        cycle();
        check("t5_valid0", out_valid_o, 1);
        check("t5_data0", $signed(out_data_o), 54);
        cycle();
        cycle();
        push(uni(16'sd1), EN_ALL, 1'b0);
        cycle();
        cycle();
        check("t5_data1", $signed(out_data_o), 63);
        check("t5_err_pre", err_o, 0);
        push(uni(16'sd1), EN_ALL, 1'b1);
        check("t5_err", err_o, 1);
        check("t5_resync_pix", dut.pix_addr, 0);
        check("t5_resync_chnl", dut.chnl_idx, 0);
        cycle();
        cycle();
        check("t5_valid2", out_valid_o, 1);
        check("t5_data2", $signed(out_data_o), 72);
        check("t5_last2", out_last_o, 0);
        check("t5_layer2", layer_done_o, 0);
        cycle();
        cycle();
        push(uni(16'sd2), EN_ALL, 1'b0);
        cycle();
        cycle();
        check("t5_chnl0_quiet", out_valid_o, 0);
        check("t5_err_sticky", err_o, 1);
        check("t5_pix_after", dut.pix_addr, 1);

        // 6. Reset mid-pipe drops the in-flight last-channel window
        do_reset();
        push(uni(16'sd0), EN_ALL, 1'b0);
        finish_chnl0();
        push(uni(16'sd3), EN_ALL, 1'b0);
        rst_n = 1'b0;
        cycle();
        check_quiet("t6_rst_a");
        cycle();
        check_quiet("t6_rst_b");
        rst_n = 1'b1;
        cycle();
        check_quiet("t6_after");
        check("t6_err", err_o, 0);
        check("t6_pix", dut.pix_addr, 0);

        // 6b. Negative final sum, with and without ReLU
        vec = '0;
        vec[0 +: PROD_W] = -16'sd50;
        push(vec, EN_ALL, 1'b0);
        finish_chnl0();
        push(uni(16'sd0), EN_ALL, 1'b0);
        cycle();
        cycle();
`ifdef CONV_PSUM_RELU_EN
        exp_relu = 0;
`else
        exp_relu = -50;
`endif
        check("t6_neg_valid", out_valid_o, 1);
        check("t6_neg_data", $signed(out_data_o), exp_relu);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_psum_accum.md
Name: conv_psum_accum

Overview:
- Downstream consumer of the window-enable counter and the 3x3 multiplier bar in the conv accelerator.
- Masks the 9 tap products with their padding enables and reduces them through a pipelined adder tree.
- Accumulates the window sum per output pixel across input channels in an internal partial-sum RAM.
- Emits the final pixel value, with optional ReLU, on the last input channel.

Parameters:
PROD_W, 16, signed width of each tap product
ACC_W, 32, signed width of partial sums and output
PIX_NUM, 12544, pixels per channel (112x112); must be >= 3
NUM_CHNL, 64, input channels accumulated per output map
ADDR_W, 14, psum RAM address width, >= clog2(PIX_NUM)
CH_W, 7, channel counter width, >= clog2(NUM_CHNL)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
valid_i  in  1  one window of products is present this cycle
prod_i  in  9*PROD_W  tap products, tap k at bits [k*PROD_W +: PROD_W], k=0..8 maps to enable1..enable9
en_i  in  9  tap enables from the counter stage; 0 means tap is padding
chnl_done_i  in  1  last pixel of current channel; only meaningful when valid_i=1
out_valid_o  out  1  out_data_o is a final (last-channel) pixel
out_data_o  out  ACC_W  final accumulated pixel
out_last_o  out  1  with out_valid_o, marks pixel PIX_NUM-1
layer_done_o  out  1  one-cycle pulse after the final pixel of the last channel is written
err_o  out  1  sticky: chnl_done_i arrived with pix_addr != PIX_NUM-1

Behaviour:
- Reset values: all outputs 0; pix_addr=0; chnl_idx=0; pipeline valids 0. RAM contents are not reset.
- pix_addr increments on each valid_i and wraps PIX_NUM-1 -> 0.
- chnl_idx increments when valid_i & chnl_done_i, and wraps NUM_CHNL-1 -> 0.
- When both counters wrap in the same cycle, layer_done_o pulses 3 cycles later, aligned with that pixel's out_valid_o.
- S1 (registered on valid_i):
  - masked tap = en ? sign-extended prod : 0.
  - Compute three row sums of 3 taps each.
  - Tag the entry's pix_addr, chnl_idx, first = (chnl_idx==0) and last = (chnl_idx==NUM_CHNL-1).
- S2: window sum = sum of the three row sums, sign-extended to ACC_W; issue the psum RAM read at the tagged address.
- S3: new = first ? window : sat(ram_rd + window).
  - sat clamps to the signed ACC_W range.
  - Write new back to the same address.
  - If last: out_valid_o=1 and out_data_o=new (ReLU applied if enabled).
- Latency valid_i -> out_valid_o is exactly 3 cycles; throughput is one window per cycle; there is no backpressure.
- RAM hazard: an address recurs only after PIX_NUM >= 3 valids, so no read-after-write forwarding is needed.
- Gaps in valid_i freeze the counters; bubbles propagate through the pipeline with no writes.
- chnl_done_i with pix_addr != PIX_NUM-1:
  - err_o is set.
  - chnl_idx still advances and pix_addr is forced to 0 (resync).
- Reset mid-operation clears the counters and pipeline immediately; in-flight windows are dropped and no write occurs.

Optional Feature:
- Macro: CONV_PSUM_RELU_EN.
- Defined: out_data_o = (new < 0) ? 0 : new on last-channel outputs; the RAM still stores the unclipped value.
- Undefined: out_data_o = new.

Decomposition:
- Shared package conv_acc_pkg holds:
  - constants FMAP_W=112, PIX_NUM, TAP_NUM=9;
  - the saturating-add function;
  - the tap index ordering shared with the counter stage.
- Sub-module psum_ram: single-clock simple dual-port RAM, PIX_NUM x ACC_W, 1-cycle registered read, write-first not required.

Test Plan (PIX_NUM=4, NUM_CHNL=2 unless stated):
1. Single window:
   - Stimulus: all prods=1, en=9'h1FF, chnl 0, then the same window at chnl 1 for pixel 0.
   - Response: out_valid_o exactly 3 cycles after the chnl-1 valid, out_data_o=18.
2. Padding mask:
   - Stimulus: prods=100, en=9'b000_011_011.
   - Response: window sum 400; the channel-1 output equals 400 + the channel-0 sum.
3. Full layer:
   - Stimulus: 8 consecutive valids, chnl_done on the 4th and 8th.
   - Response: 4 outputs; out_last_o on the 4th; layer_done_o on the same cycle; counters return to 0.
4. Saturation:
   - Stimulus: ACC_W=20; two channels, each window sum 2^18.
   - Response: out_data_o = 2^19-1.
5. Bubbles and misalignment:
   - Stimulus: valid_i gaps between windows; then chnl_done with pix_addr=2.
   - Response: results unchanged by the gaps; err_o=1 and stays 1; pix_addr resyncs to 0.
6. Reset mid-pipe and ReLU:
   - Stimulus: assert rst_n low 1 cycle after valid_i.
   - Response: no out_valid_o and all outputs 0.
   - With CONV_PSUM_RELU_EN, a negative final sum -50 outputs 0; without the macro it outputs -50.
